// File: rtl/rst_seq_ctrl.sv
// Purpose: PLL-lock-qualified reset sequencer; releases CHANNELS active-low domain resets in order.
// Latency: sys_rst_n[i] rises 2 + LOCK_STABLE + (i+1)*STAGE_DELAY edges after lock is first sampled.
// Backpressure: none; free-running, inputs are level-sampled every cycle.
//
// Ports:
//   clk           free-running board clock (independent of the PLL)
//   rst_n         asynchronous active-low global reset
//   pll_locked    PLL lock flag, asynchronous to clk (synchronised internally)
//   soft_rst_req  synchronous level-sampled soft reset request
//   sys_rst_n     per-domain active-low resets, bit 0 released first
//   seq_done      high while every channel is released
//   locked_sync   synchronised pll_locked
//   lock_lost_cnt saturating count of lock losses seen after lock qualification
module rst_seq_ctrl #(
    parameter int CHANNELS    = 4,
    parameter int STAGE_DELAY = 1000,
    parameter int LOCK_STABLE = 256,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pll_locked,
    input  logic                soft_rst_req,
    output logic [CHANNELS-1:0] sys_rst_n,
    output logic                seq_done,
    output logic                locked_sync,
    output logic [CNT_W-1:0]    lock_lost_cnt
);

    // Counter widths: each counter only ever reaches its terminal value, which is compared exactly.
    localparam int SW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam int DW = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int CW = (CHANNELS > 1)    ? $clog2(CHANNELS)    : 1;

    localparam logic [SW-1:0]       STAB_LAST = SW'(LOCK_STABLE - 1);
    localparam logic [DW-1:0]       DLY_LAST  = DW'(STAGE_DELAY - 1);
    localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]       CH_LAST   = CW'(CHANNELS - 1);
    localparam logic [CHANNELS-1:0] CH_ONE    = CHANNELS'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        HOLD
    } state_t;

    state_t               state_q;
    logic [1:0]           sync_q;
    logic [SW-1:0]        stab_cnt_q;
    logic [DW-1:0]        dly_cnt_q;
    logic [HW-1:0]        hold_cnt_q;
    logic [CW-1:0]        ch_idx_q;
    logic [CHANNELS-1:0]  sys_rst_n_q;
    logic                 seq_done_q;
    logic [CNT_W-1:0]     lost_cnt_q;
    logic                 locked_s;

    assign locked_s = sync_q[1];

    // Two-flop synchroniser for the asynchronous lock flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            stab_cnt_q  <= '0;
            dly_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            ch_idx_q    <= '0;
            sys_rst_n_q <= '0;
            seq_done_q  <= 1'b0;
            lost_cnt_q  <= '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_q    <= STABLE;
                        stab_cnt_q <= '0;
                    end
                end

                // A drop here is treated as a lock glitch and is not counted.
                STABLE: begin
                    if (!locked_s) begin
                        state_q <= WAIT_LOCK;
                    end else if (stab_cnt_q == STAB_LAST) begin
                        state_q   <= RELEASE;
                        ch_idx_q  <= '0;
                        dly_cnt_q <= '0;
                    end else begin
                        stab_cnt_q <= stab_cnt_q + SW'(1);
                    end
                end

                RELEASE, RUN, HOLD: begin
                    // Lock loss takes priority over a soft reset on the same edge.
                    if (!locked_s) begin
                        state_q     <= WAIT_LOCK;
                        sys_rst_n_q <= '0;
                        seq_done_q  <= 1'b0;
                        if (lost_cnt_q != CNT_MAX) begin
                            lost_cnt_q <= lost_cnt_q + CNT_W'(1);
                        end
                    end else if (soft_rst_req && (state_q != HOLD)) begin
                        state_q     <= HOLD;
                        hold_cnt_q  <= '0;
                        sys_rst_n_q <= '0;
                        seq_done_q  <= 1'b0;
                    end else if (state_q == RELEASE) begin
                        if (dly_cnt_q == DLY_LAST) begin
                            sys_rst_n_q <= sys_rst_n_q | (CH_ONE << ch_idx_q);
                            dly_cnt_q   <= '0;
                            if (ch_idx_q == CH_LAST) begin
                                state_q    <= RUN;
                                seq_done_q <= 1'b1;
                            end else begin
                                ch_idx_q <= ch_idx_q + CW'(1);
                            end
                        end else begin
                            dly_cnt_q <= dly_cnt_q + DW'(1);
                        end
                    end else if (state_q == HOLD) begin
                        // Lock is still qualified, so resume straight at channel 0.
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_q   <= RELEASE;
                            ch_idx_q  <= '0;
                            dly_cnt_q <= '0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + HW'(1);
                        end
                    end
                end

                default: begin
                    state_q     <= WAIT_LOCK;
                    sys_rst_n_q <= '0;
                    seq_done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sys_rst_n     = sys_rst_n_q;
    assign seq_done      = seq_done_q;
    assign locked_sync   = locked_s;
    assign lock_lost_cnt = lost_cnt_q;

endmodule
